// File: rtl/mips_pkg.sv
// Shared MIPS R-type definitions: funct codes, opcode, controller states, field positions.
package mips_pkg;

  typedef enum logic [5:0] {
    F_SLL  = 6'h00,
    F_SRL  = 6'h02,
    F_SRA  = 6'h03,
    F_SLLV = 6'h04,
    F_SRLV = 6'h06,
    F_SRAV = 6'h07,
    F_ADD  = 6'h20,
    F_SUB  = 6'h22,
    F_AND  = 6'h24,
    F_OR   = 6'h25,
    F_XOR  = 6'h26,
    F_SLT  = 6'h2A
  } funct_e;

  localparam logic [5:0] RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

endpackage

// File: rtl/rtype_funct_decode.sv
// Combinational funct classifier: which codes we execute and how shifts source their amount.
module rtype_funct_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic       legal,
  output logic       shift_imm,
  output logic       shift_var
);

  // Classify the funct field; anything outside the supported set is flagged not legal
  always_comb begin
    legal     = 1'b0;
    shift_imm = 1'b0;
    shift_var = 1'b0;
    case (funct)
      F_SLL, F_SRL, F_SRA: begin
        legal     = 1'b1;
        shift_imm = 1'b1;
      end
      F_SLLV, F_SRLV, F_SRAV: begin
        legal     = 1'b1;
        shift_var = 1'b1;
      end
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT: begin
        legal = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// R-type issue/writeback controller driving a combinational ALU and a register file.
// Optional feature macro: ALU_ISSUE_OVERFLOW_EN adds an overflow port; signed ADD/SUB
// overflow then squashes the writeback and pulses overflow together with done.
module alu_issue_ctrl
  import mips_pkg::*;
#(
  parameter int SUPPRESS_R0 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_sa,
  output logic [5:0]  alu_op,
  input  logic [31:0] alu_r,
  output logic        rf_we,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        done,
  output logic        illegal
`ifdef ALU_ISSUE_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] rs_q, rt_q, r_q;

  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic [5:0]  op_f, fn_f;
  logic        fn_legal, shift_imm, shift_var, legal;
  logic        squash_r0, squash_ovf;

  assign op_f = instr_q[OP_MSB:OP_LSB];
  assign rs_f = instr_q[RS_MSB:RS_LSB];
  assign rt_f = instr_q[RT_MSB:RT_LSB];
  assign rd_f = instr_q[RD_MSB:RD_LSB];
  assign sh_f = instr_q[SH_MSB:SH_LSB];
  assign fn_f = instr_q[FN_MSB:FN_LSB];

  rtype_funct_decode u_decode (
    .funct     (fn_f),
    .legal     (fn_legal),
    .shift_imm (shift_imm),
    .shift_var (shift_var)
  );

  assign legal     = (op_f == RTYPE) && fn_legal;
  assign squash_r0 = (SUPPRESS_R0 != 0) && (rd_f == 5'd0);

`ifdef ALU_ISSUE_OVERFLOW_EN
  logic ovf_q, ovf_c;

  // Signed overflow: ADD with like-signed operands or SUB with unlike-signed operands
  // whose result sign differs from operand a
  always_comb begin
    ovf_c = 1'b0;
    if (fn_f == F_ADD)
      ovf_c = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
    else if (fn_f == F_SUB)
      ovf_c = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
  end

  // Overflow flag is cleared in READ and captured alongside the ALU result in EXEC
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state_q == READ)
      ovf_q <= 1'b0;
    else if (state_q == EXEC)
      ovf_q <= ovf_c;
  end

  assign squash_ovf = ovf_q;
  assign overflow   = done && ovf_q;
`else
  assign squash_ovf = 1'b0;
`endif

  // State register plus the instruction, operand and result capture points
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (instr_valid) instr_q <= instr;
        READ: begin
          rs_q <= rf_rs_data;
          rt_q <= rf_rt_data;
          r_q  <= '0;
        end
        EXEC: r_q <= alu_r;
        default: ;
      endcase
    end
  end

  // Next-state and output decode; a low rst_n forces the idle output values for the cycle
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_rs_addr  = '0;
    rf_rt_addr  = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_sa      = '0;
    alu_op      = '0;
    rf_we       = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = READ;
      end
      READ: begin
        rf_rs_addr = rs_f;
        rf_rt_addr = rt_f;
        state_d    = legal ? EXEC : WB;
      end
      EXEC: begin
        alu_op = fn_f;
        if (shift_imm) begin
          alu_a  = rt_q;
          alu_sa = {1'b0, sh_f};
        end else if (shift_var) begin
          alu_a = rt_q;
          alu_b = rs_q;
        end else begin
          alu_a = rs_q;
          alu_b = rt_q;
        end
        state_d = WB;
      end
      WB: begin
        done       = 1'b1;
        illegal    = !legal;
        rf_wr_addr = rd_f;
        rf_wr_data = r_q;
        rf_we      = legal && !squash_r0 && !squash_ovf;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      state_d     = IDLE;
      instr_ready = 1'b1;
      rf_rs_addr  = '0;
      rf_rt_addr  = '0;
      alu_a       = '0;
      alu_b       = '0;
      alu_sa      = '0;
      alu_op      = '0;
      rf_we       = 1'b0;
      rf_wr_addr  = '0;
      rf_wr_data  = '0;
      done        = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a register-file/ALU model and a result scoreboard.
module tb_alu_issue_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [5:0]  alu_sa, alu_op;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        done, illegal;
  logic        ovf_sig;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ill;
    logic        ovf;
    int          lat;
    logic        chk_alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sa;
    logic [5:0]  op;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_rs_addr  (rf_rs_addr),
    .rf_rt_addr  (rf_rt_addr),
    .rf_rs_data  (rf_rs_data),
    .rf_rt_data  (rf_rt_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sa      (alu_sa),
    .alu_op      (alu_op),
    .alu_r       (alu_r),
    .rf_we       (rf_we),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .done        (done),
    .illegal     (illegal)
`ifdef ALU_ISSUE_OVERFLOW_EN
    ,
    .overflow    (ovf_sig)
`endif
  );

`ifndef ALU_ISSUE_OVERFLOW_EN
  assign ovf_sig = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd5;
      5'd2:    return 32'd7;
      5'd4:    return 32'h1;
      5'd6:    return 32'd2;
      5'd7:    return 32'h8000_0000;
      5'd8:    return 32'h7FFF_FFFF;
      5'd10:   return 32'd1;
      5'd11:   return 32'h0000_F0F0;
      5'd12:   return 32'h0000_0FF0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [31:0] a, b,
                                            input logic [5:0] sa);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h00:   return a << sa[4:0];
      6'h02:   return a >> sa[4:0];
      6'h03:   return $unsigned($signed(a) >>> sa[4:0]);
      6'h04:   return a << b[4:0];
      6'h06:   return a >> b[4:0];
      6'h07:   return $unsigned($signed(a) >>> b[4:0]);
      6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign rf_rs_data = reg_val(rf_rs_addr);
  assign rf_rt_data = reg_val(rf_rt_addr);
  assign alu_r      = alu_model(alu_op, alu_a, alu_b, alu_sa);

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic exp_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data,
                              input logic ill, input logic ovf, input int lat,
                              input logic chk_alu, input logic [31:0] a, b,
                              input logic [5:0] sa, op);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.ill = ill; e.ovf = ovf; e.lat = lat;
    e.chk_alu = chk_alu; e.a = a; e.b = b; e.sa = sa; e.op = op;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] word, input exp_t e);
    int w;
    w = 0;
    @(negedge clk);
    while (!instr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s.accept observed=not_ready expected=ready", name);
    end
    instr_valid = 1'b1;
    instr       = word;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    int   k;
    logic seen;
    e    = sb.pop_front();
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 8) begin
      @(negedge clk);
      k++;
      if (e.chk_alu && k == 2) begin
        chk({name, ".alu_a"},  alu_a, e.a);
        chk({name, ".alu_b"},  alu_b, e.b);
        chk({name, ".alu_sa"}, {26'd0, alu_sa}, {26'd0, e.sa});
        chk({name, ".alu_op"}, {26'd0, alu_op}, {26'd0, e.op});
      end
      if (done) seen = 1'b1;
    end
    chk({name, ".latency"}, k, e.lat);
    chk({name, ".rf_we"},   {31'd0, rf_we},   {31'd0, e.we});
    chk({name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
`ifdef ALU_ISSUE_OVERFLOW_EN
    chk({name, ".overflow"}, {31'd0, ovf_sig}, {31'd0, e.ovf});
`endif
    if (e.we) begin
      chk({name, ".wr_addr"}, {27'd0, rf_wr_addr}, {27'd0, e.addr});
      chk({name, ".wr_data"}, rf_wr_data, e.data);
    end
    @(negedge clk);
    chk({name, ".ready_after"}, {31'd0, instr_ready}, 32'd1);
  endtask

  // Directed sequence: reset, legal ops, illegal ops, r0 squash, overflow, reset mid-flight
  initial begin
    int bad;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset.ready",   {31'd0, instr_ready}, 32'd1);
    chk("reset.rf_we",   {31'd0, rf_we}, 32'd0);
    chk("reset.done",    {31'd0, done}, 32'd0);
    chk("reset.alu_op",  {26'd0, alu_op}, 32'd0);
    chk("reset.wr_data", rf_wr_data, 32'd0);
    rst_n = 1'b1;

    applyStimulus("add", rtype(5'd1, 5'd2, 5'd3, 5'd0, F_ADD),
                  mk(1, 5'd3, 32'd12, 0, 0, 3, 1, 32'd5, 32'd7, 6'd0, 6'h20));
    checkOutput("add");

    applyStimulus("sll", rtype(5'd0, 5'd4, 5'd5, 5'd4, F_SLL),
                  mk(1, 5'd5, 32'h10, 0, 0, 3, 1, 32'h1, 32'd0, 6'd4, 6'h00));
    checkOutput("sll");

    applyStimulus("srav", rtype(5'd6, 5'd7, 5'd13, 5'd0, F_SRAV),
                  mk(1, 5'd13, 32'hE000_0000, 0, 0, 3, 1, 32'h8000_0000, 32'd2, 6'd0, 6'h07));
    checkOutput("srav");

    applyStimulus("lw", 32'h8C00_0000,
                  mk(0, 5'd0, 32'd0, 1, 0, 2, 0, 32'd0, 32'd0, 6'd0, 6'd0));
    checkOutput("lw");

    applyStimulus("badfn", rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h01),
                  mk(0, 5'd0, 32'd0, 1, 0, 2, 0, 32'd0, 32'd0, 6'd0, 6'd0));
    checkOutput("badfn");

    applyStimulus("and_r0", rtype(5'd11, 5'd12, 5'd0, 5'd0, F_AND),
                  mk(0, 5'd0, 32'd0, 0, 0, 3, 1, 32'h0000_F0F0, 32'h0000_0FF0, 6'd0, 6'h24));
    checkOutput("and_r0");

    applyStimulus("sub", rtype(5'd2, 5'd1, 5'd14, 5'd0, F_SUB),
                  mk(1, 5'd14, 32'd2, 0, 0, 3, 1, 32'd7, 32'd5, 6'd0, 6'h22));
    checkOutput("sub");

`ifdef ALU_ISSUE_OVERFLOW_EN
    applyStimulus("add_ovf", rtype(5'd8, 5'd10, 5'd15, 5'd0, F_ADD),
                  mk(0, 5'd15, 32'h8000_0000, 0, 1, 3, 1, 32'h7FFF_FFFF, 32'd1, 6'd0, 6'h20));
`else
    applyStimulus("add_ovf", rtype(5'd8, 5'd10, 5'd15, 5'd0, F_ADD),
                  mk(1, 5'd15, 32'h8000_0000, 0, 0, 3, 1, 32'h7FFF_FFFF, 32'd1, 6'd0, 6'h20));
`endif
    checkOutput("add_ovf");

    applyStimulus("rst_exec", rtype(5'd1, 5'd2, 5'd9, 5'd0, F_OR),
                  mk(1, 5'd9, 32'd7, 0, 0, 3, 1, 32'd5, 32'd7, 6'd0, 6'h25));
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst_exec.alu_a", alu_a, 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_exec.ready", {31'd0, instr_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rf_we || done) bad++;
    end
    chk("rst_exec.no_wb", bad, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
